// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for a 5-stage MIPS pipeline: load-use bubbles,
// taken-branch flushes and HI/LO read-after-mult/div stalls.
module hazard_stall_ctrl #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             mfhilo_id,
  input  logic [4:0]       rw_ex,
  input  logic             regWr_ex,
  input  logic             mem2Reg_ex,
  input  logic             md_issue_ex,
  input  logic             branch_taken_ex,
  output logic             pc_wr,
  output logic             ifid_wr,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned MdW = 4;

  typedef enum logic [1:0] {StRun, StLu, StMdw} state_e;

  state_e           state_q, state_d;
  logic [MdW-1:0]   md_cnt_q, md_cnt_d;
  logic [1:0]       bubble_q, bubble_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_ex, lu_rs, lu_rt, lu, md_haz;

  // A load only matters if it really writes a non-zero register.
  assign load_ex = mem2Reg_ex & regWr_ex & (rw_ex != 5'd0);
  assign lu_rs   = load_ex & use_rs_id & (rs_id == rw_ex);
  assign lu_rt   = load_ex & use_rt_id & (rt_id == rw_ex);
  assign lu      = lu_rs | lu_rt;
  assign md_haz  = mfhilo_id & ((md_cnt_q != '0) | md_issue_ex);

  always_comb begin
    pc_wr      = 1'b1;
    ifid_wr    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    bubble_d   = 2'b00;
    if (branch_taken_ex) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu || md_haz) begin
      pc_wr      = 1'b0;
      ifid_wr    = 1'b0;
      idex_flush = 1'b1;
      if (lu) bubble_d = {lu_rs, lu_rt};
    end
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_issue_ex) begin
      md_cnt_d = MdW'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MdW'(1);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_wr && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // The state only records why the pipeline is held; outputs follow the live hazard terms.
  always_comb begin
    state_d = state_q;
    if (branch_taken_ex) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun:   state_d = lu ? StLu : (md_haz ? StMdw : StRun);
        StLu:    state_d = md_haz ? StMdw : StRun;
        StMdw:   state_d = md_haz ? StMdw : StRun;
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      md_cnt_q    <= '0;
      bubble_q    <= 2'b00;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      bubble_q    <= bubble_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bubble    = bubble_q;
  assign stall_cnt = stall_cnt_q;

endmodule
